// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// if_id_t fields are XLEN wide; fetch_stage DATA_WIDTH must equal XLEN.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] FETCH_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        StBoot,
        StRun
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
        logic            fault;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, bubble load and stall hold.
// A bubble keeps the capture PC/PC+4 but replaces the instruction with a NOP.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   stall_i,
    input  logic   bubble_i,
    input  if_id_t capture_i,
    output if_id_t if_id_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    always_comb begin
        if_id_d = if_id_q;
        if (bubble_i) begin
            if_id_d.pc    = capture_i.pc;
            if_id_d.pc4   = capture_i.pc4;
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
            if_id_d.fault = 1'b0;
        end else if (!stall_i) begin
            if_id_d = capture_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_q.pc    <= '0;
            if_id_q.pc4   <= '0;
            if_id_q.instr <= NOP_INSTR;
            if_id_q.valid <= 1'b0;
            if_id_q.fault <= 1'b0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, BOOT/RUN sequencing, next-PC mux, fetch-fault decode.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/bubble_cnt performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter int unsigned           ADDR_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = FETCH_NOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  flush_d,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] pc_f,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc4_d,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic                  valid_d,
    output logic                  fault_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  fetch_fault;
    logic                  if_bubble;
    logic                  if_stall;
    if_id_t                capture;
    if_id_t                if_id;

    assign pc_plus4    = pc_f_q + DATA_WIDTH'(4);
    assign fetch_fault = (pc_f_q[1:0] != 2'b00) || (pc_f_q[DATA_WIDTH-1:ADDR_WIDTH] != '0);

    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        if_bubble = 1'b0;
        if_stall  = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d   = StRun;
                if_bubble = 1'b1;
                if (redirect_valid) begin
                    pc_f_d = redirect_pc;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    pc_f_d = redirect_pc;
                end else if (!stall_f) begin
                    pc_f_d = pc_plus4;
                end
                // Redirect squashes the wrong-path word even while stalled.
                if (flush_d || redirect_valid) begin
                    if_bubble = 1'b1;
                end else if (stall_f) begin
                    if_stall = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_f_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
        end
    end

    always_comb begin
        capture.pc    = pc_f_q;
        capture.pc4   = pc_plus4;
        capture.instr = fetch_fault ? NOP_INSTR : imem_rdata;
        capture.valid = 1'b1;
        capture.fault = fetch_fault;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i     (clk),
        .rst_i     (rst),
        .stall_i   (if_stall),
        .bubble_i  (if_bubble),
        .capture_i (capture),
        .if_id_o   (if_id)
    );

    assign imem_addr = pc_f_q[ADDR_WIDTH-1:0];
    assign pc_f      = pc_f_q;
    assign pc_d      = if_id.pc;
    assign pc4_d     = if_id.pc4;
    assign instr_d   = if_id.instr;
    assign valid_d   = if_id.valid;
    assign fault_d   = if_id.fault;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (!if_bubble && !if_stall) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (if_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
